imm_ext_arbiter: RTL

// Shares one immediate sign/zero-extension unit between two requesters: req0 (decode stage)
// and req1 (branch-target unit). Round-robin arbiter, one-entry registered output with

---
 rtl/imm_ext_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imm_ext_arbiter.sv
// Shared immediate sign/zero-extension unit for two requesters: decode (req0)
// and branch-target (req1). Round-robin arbitration feeds a one-entry
// registered output stage with valid/ready backpressure.
//
// state | meaning
// ------+----------------------------------------------------------
// EMPTY | output register holds no result, out_valid low
// FULL  | output register holds a result for out_id, out_valid high
module imm_ext_arbiter #(
  parameter int DATA_W  = 16,
  parameter int IMM_A_W = 12,
  parameter int IMM_B_W = 10
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_in,
  input  logic              req0_imSlct,
  input  logic              req0_zext,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_in,
  input  logic              req1_imSlct,
  input  logic              req1_zext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   data_q;
  logic                id_q;
  logic                rr_last_q;

  logic                can_accept;
  logic                grant0;
  logic                grant1;
  logic                xfer;
  logic [DATA_W-1:0]   sel_in;
  logic                sel_imslct;
  logic                sel_zext;
  logic [DATA_W-1:0]   data_d;
  logic                id_d;

  // Extension: low field bits pass through, upper bits are zero or a copy of
  // the field's top bit. The raw word is only read, never altered.
  function automatic logic [DATA_W-1:0] ext_imm(
    input logic [DATA_W-1:0] raw,
    input logic              imslct,
    input logic              zext
  );
    logic [DATA_W-1:0] res;
    logic              sign_a;
    logic              sign_b;
    res    = '0;
    sign_a = raw[IMM_A_W-1];
    sign_b = raw[IMM_B_W-1];
    for (int i = 0; i < DATA_W; i++) begin
      if (imslct) begin
        if (i < IMM_B_W) res[i] = raw[i];
        else             res[i] = zext ? 1'b0 : sign_b;
      end else begin
        if (i < IMM_A_W) res[i] = raw[i];
        else             res[i] = zext ? 1'b0 : sign_a;
      end
    end
    return res;
  endfunction

  // Grant logic: the output slot must be free or draining this cycle; on a
  // tie the requester that did not win last time gets the slot. Grants are
  // suppressed while reset is held so nothing is accepted during reset.
  always_comb begin
    can_accept = (state_q == EMPTY) || out_ready;
    grant0     = reset && can_accept && req0_valid && (!req1_valid || rr_last_q);
    grant1     = reset && can_accept && req1_valid && (!req0_valid || !rr_last_q);
    xfer       = grant0 || grant1;
  end

  // Payload select and extension for whichever requester is granted.
  always_comb begin
    sel_in     = grant1 ? req1_in     : req0_in;
    sel_imslct = grant1 ? req1_imSlct : req0_imSlct;
    sel_zext   = grant1 ? req1_zext   : req0_zext;
    data_d     = ext_imm(sel_in, sel_imslct, sel_zext);
    id_d       = grant1;
  end

  // Output-stage FSM: loads a result on transfer, empties on consume without
  // a new transfer, and holds everything while stalled.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q   <= EMPTY;
      data_q    <= '0;
      id_q      <= 1'b0;
      rr_last_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer) begin
            state_q   <= FULL;
            data_q    <= data_d;
            id_q      <= id_d;
            rr_last_q <= id_d;
          end
        end
        FULL: begin
          if (xfer) begin
            data_q    <= data_d;
            id_q      <= id_d;
            rr_last_q <= id_d;
          end else if (out_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign out_valid  = (state_q == FULL);
  assign out_data   = data_q;
  assign out_id     = id_q;

endmodule
